// File: rtl/buyruk_bellek_yanitlayici.sv
// Instruction-memory responder for the fetch port.
// Single outstanding request, fixed latency, held response, preload port.
module buyruk_bellek_yanitlayici #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 32,
  parameter int DERINLIK  = 1024,
  parameter int GECIKME   = 5,
  parameter logic [ADRES_BIT-1:0] ADRES_MASKE = 32'h0000_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [ADRES_BIT-1:0] istek_adres_i,
  input  logic                 istek_gecerli_i,
  output logic                 istek_hazir_o,
  output logic [BLOK_BIT-1:0]  yanit_veri_o,
  output logic                 yanit_gecerli_o,
  input  logic                 yanit_hazir_i,
  input  logic                 yukle_gecerli_i,
  input  logic [ADRES_BIT-1:0] yukle_adres_i,
  input  logic [BLOK_BIT-1:0]  yukle_veri_i
);

  localparam int IDX_BIT = $clog2(DERINLIK);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] BEKLE = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;

  localparam logic [5:0] SAYAC_ILK = 6'(GECIKME - 1);

  logic [BLOK_BIT-1:0]  mem [DERINLIK];

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [5:0]           sayac;
  logic                 hazir;
  logic                 gecerli;
  logic [BLOK_BIT-1:0]  veri;

  logic                 kabul;
  logic                 teslim;
  logic [ADRES_BIT-1:0] istek_maskeli;
  logic [ADRES_BIT-1:0] yukle_maskeli;
  logic [IDX_BIT-1:0]   istek_idx;
  logic [IDX_BIT-1:0]   yukle_idx;
  logic                 unused_bitler;

  // Byte offset dropped, high bits wrap modulo the depth.
  assign istek_maskeli = istek_adres_i & ADRES_MASKE;
  assign yukle_maskeli = yukle_adres_i & ADRES_MASKE;
  assign istek_idx     = istek_maskeli[IDX_BIT+1:2];
  assign yukle_idx     = yukle_maskeli[IDX_BIT+1:2];

  assign unused_bitler = ^{istek_maskeli[ADRES_BIT-1:IDX_BIT+2],
                           istek_maskeli[1:0],
                           yukle_maskeli[ADRES_BIT-1:IDX_BIT+2],
                           yukle_maskeli[1:0]};

  assign kabul  = istek_gecerli_i & hazir;
  assign teslim = gecerli & yanit_hazir_i;

  assign istek_hazir_o   = hazir;
  assign yanit_gecerli_o = gecerli;
  assign yanit_veri_o    = veri;

  // Storage is never reset so a preload survives core resets.
  always_ff @(posedge clk_i) begin
    if (yukle_gecerli_i) begin
      mem[yukle_idx] <= yukle_veri_i;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOSTA: begin
        if (kabul) begin
          state_next = (GECIKME == 1) ? YANIT : BEKLE;
        end
      end
      BEKLE: begin
        if (sayac == 6'd1) begin
          state_next = YANIT;
        end
      end
      YANIT: begin
        if (teslim) begin
          state_next = BOSTA;
        end
      end
      default: state_next = BOSTA;
    endcase
  end

  // Handshake flags are registered from the next state, so
  // ready stays low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= BOSTA;
      hazir   <= 1'b0;
      gecerli <= 1'b0;
      veri    <= '0;
      sayac   <= '0;
    end else begin
      state   <= state_next;
      hazir   <= (state_next == BOSTA);
      gecerli <= (state_next == YANIT);
      if (kabul) begin
        veri  <= mem[istek_idx];
        sayac <= SAYAC_ILK;
      end else if (state == BEKLE) begin
        sayac <= sayac - 6'd1;
      end
    end
  end

endmodule
